bnn_seq_ctrl: RTL
=================

# bnn_seq_ctrl

Multi-cycle sequencer for the custom BNN instructions (opcode 7'b1111111). It holds the matrix-size and activation-threshold configuration registers written by BNNCMS/BNNCAT. For BCNV/BNN it XNORs the two operands over a k×k window and popcounts the result serially, one row per cycle. For BNN it optionally binarizes the count against the threshold. It sits beside the Execute stage, stalls the pipeline while counting, and returns a 32-bit result for write-back.

## Interface
- XLEN, 32, operand/result width
- KMAX, 5, largest legal window dimension k (KMAX*KMAX ≤ XLEN)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start_E  in  1  BCNV/BNN instruction valid in Execute
- op_bnn_E  in  1  0 = BCNV (raw count), 1 = BNN (thresholdable)
- en_threshold_E  in  1  BNN only: binarize against threshold
- ms_WE_E  in  1  write matrix-size register
- at_WE_E  in  1  write activation-threshold register
- cfg_data_E  in  XLEN  config write data
- opA_E, opB_E  in  XLEN  packed binary operands, row-major, bit r*k+c
- busy  out  1  pipeline stall request
- done  out  1  one-cycle result-valid pulse
- result  out  XLEN  count or binarized value
- cfg_err  out  1  sticky flag for an illegal matrix-size write
- ms_q  out  3  current k
- at_q  out  5  current threshold

## Operation
- Reset values: ms_q=3, at_q=0, state IDLE, acc=0, row=0, busy=0, done=0, result=0, cfg_err=0.
- Config:
  - ms_WE_E writes cfg_data_E[2:0] if the value is in 1..KMAX.
  - Otherwise the register is unchanged and cfg_err is set. cfg_err clears only on reset.
  - at_WE_E writes cfg_data_E[4:0].
  - Writes are accepted in any state. A running operation uses its latched k and threshold, so writes affect only later operations.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - On start_E, latch k=ms_q, thr=at_q, mode bits, and vec = ~(opA_E^opB_E) masked to the low k*k bits.
  - Clear acc and row, then go to COUNT.
  - If start_E and ms_WE_E coincide, the operation uses the old ms_q.
- COUNT:
  - Each cycle, acc += popcount(vec[row*k +: k]) and row++.
  - When row==k-1, go to DONE in the same cycle as the last add.
- DONE:
  - done=1 for one cycle, then return to IDLE.
  - result = acc zero-extended, unless op_bnn && en_threshold, in which case result = {31'b0, acc ≥ thr}.
  - result holds its value until the next DONE.
- en_threshold_E is ignored for BCNV.
- acc is 5 bits wide (max 25). No overflow is possible.
- start_E while not in IDLE is ignored; the pipeline is stalled, so this is illegal by construction.
- Reset mid-operation aborts immediately to reset values. Config registers also return to their reset values.

## Timing
- busy = start_E in IDLE (combinational) OR state==COUNT. busy is low in DONE, so the stalled instruction advances in the DONE cycle and captures result.
- Latency from the start_E edge:
  - k cycles in COUNT, plus 1 cycle in DONE.
  - done is asserted in cycle k+1 after the acceptance edge (k=3 → 4 cycles).
- A back-to-back start_E is accepted the cycle after DONE, i.e. in IDLE.
- Config registers update on the clock edge with WE high. ms_q and at_q are visible the next cycle.
- All outputs except busy are registered.

## Test plan
- Reset, then BCNV with k=3, opA=0x1FF, opB=0x1FF → busy for 3 cycles, done on cycle 4, result=9.
- at_WE=1 with data 5, then BNN with en_threshold=1, opA=0x000, opB=0x1F0 → xnor=0x00F, count 4 < 5, result=0. Repeat with opB=0x000 → count 9, result=1.
- ms_WE with data 5, then BCNV with opA=0x1FFFFFF, opB=0 → result=0, done on cycle 6. opA=opB=0xFFFFFFFF → result=25, with bits above 24 ignored.
- ms_WE with data 6, then data 0 → ms_q stays 3 and cfg_err=1 persists. ms_WE=4 in the same cycle as start_E → that operation uses k=3, the next uses k=4.
- Assert reset during COUNT row 1 → busy, done, acc, and result drop to 0 asynchronously. A fresh start_E after release completes normally.
- BNN with en_threshold=0, k=2, opA=0x5, opB=0x0 → result=2 (raw count). BCNV with en_threshold=1 → raw count, not binarized.

Source files
------------

// File: rtl/bnn_seq_ctrl.sv
// bnn_seq_ctrl: serial XNOR-popcount sequencer for BCNV/BNN with matrix-size and threshold config.
module bnn_seq_ctrl #(
  parameter int XLEN = 32,
  parameter int KMAX = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_E,
  input  logic            op_bnn_E,
  input  logic            en_threshold_E,
  input  logic            ms_WE_E,
  input  logic            at_WE_E,
  input  logic [XLEN-1:0] cfg_data_E,
  input  logic [XLEN-1:0] opA_E,
  input  logic [XLEN-1:0] opB_E,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            cfg_err,
  output logic [2:0]      ms_q,
  output logic [4:0]      at_q
);
  localparam logic [2:0] KM = 3'(KMAX);
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] ms_d, k_q, k_d, row_q, row_d;
  logic [4:0] at_d, thr_q, thr_d, acc_q, acc_d, pc;
  logic th_q, th_d, done_q, done_d, err_q, err_d, ms_ok;
  logic [XLEN-1:0] vec_q, vec_d, result_q, result_d;
  logic [5:0] kk;
  logic [KMAX-1:0] row_bits;
  logic unused_cfg;
  assign kk = {3'b0, ms_q} * {3'b0, ms_q};
  assign ms_ok = cfg_data_E[2:0] != 3'd0 && cfg_data_E[2:0] <= KM;
  // vec_q shifts down one row per cycle, so the current row is always its low k bits
  assign row_bits = vec_q[KMAX-1:0] & ~({KMAX{1'b1}} << k_q);
  assign busy = (state_q == IDLE && start_E) || state_q == COUNT;
  assign done = done_q;
  assign result = result_q;
  assign cfg_err = err_q;
  assign unused_cfg = ^cfg_data_E[XLEN-1:5];
  always_comb begin
    pc = '0;
    for (int i = 0; i < KMAX; i++) pc = pc + 5'(row_bits[i]);
  end
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    thr_d = thr_q;
    th_d = th_q;
    vec_d = vec_q;
    acc_d = acc_q;
    row_d = row_q;
    done_d = 1'b0;
    result_d = result_q;
    ms_d = (ms_WE_E && ms_ok) ? cfg_data_E[2:0] : ms_q;
    err_d = err_q | (ms_WE_E && !ms_ok);
    at_d = at_WE_E ? cfg_data_E[4:0] : at_q;
    case (state_q)
      IDLE: if (start_E) begin
        k_d = ms_q;
        thr_d = at_q;
        th_d = op_bnn_E & en_threshold_E;
        vec_d = ~(opA_E ^ opB_E) & ((XLEN'(1) << kk) - XLEN'(1));
        acc_d = '0;
        row_d = '0;
        state_d = COUNT;
      end
      COUNT: begin
        acc_d = acc_q + pc;
        row_d = row_q + 3'd1;
        vec_d = vec_q >> k_q;
        if (row_q == k_q - 3'd1) begin
          state_d = DONE;
          done_d = 1'b1;
          result_d = th_q ? {{(XLEN-1){1'b0}}, acc_d >= thr_q} : {{(XLEN-5){1'b0}}, acc_d};
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ms_q <= 3'd3;
      at_q <= '0;
      err_q <= 1'b0;
      k_q <= '0;
      thr_q <= '0;
      th_q <= 1'b0;
      vec_q <= '0;
      acc_q <= '0;
      row_q <= '0;
      done_q <= 1'b0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      ms_q <= ms_d;
      at_q <= at_d;
      err_q <= err_d;
      k_q <= k_d;
      thr_q <= thr_d;
      th_q <= th_d;
      vec_q <= vec_d;
      acc_q <= acc_d;
      row_q <= row_d;
      done_q <= done_d;
      result_q <= result_d;
    end
  end
endmodule
